// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared pixel-path constants and helpers
// Purpose: common pixel width, fill colour and frame geometry for the pixel paths.
// Contents: PIX_W, PIX_BLACK, FRAME_W, FRAME_H, FRAME_PIXELS_DEF, cnt_width().
package sobel_pkg;

   localparam int PIX_W = 24;
   localparam logic [PIX_W-1:0] PIX_BLACK = 24'h000000;
   localparam int FRAME_W = 640;
   localparam int FRAME_H = 480;
   localparam int FRAME_PIXELS_DEF = FRAME_W * FRAME_H;

   // Counter width for n states; never below one bit so a 1-pixel frame still builds.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pixel_reg_slice.sv
// rtl/pixel_reg_slice.sv - one-stage valid/ready register slice
// Purpose: registers a payload on a valid/ready stream with full throughput.
// Ports:
//   clk, rst          clock, async active-high reset
//   s_valid/s_data    upstream beat offered
//   s_ready           upstream may load (output empty or being drained)
//   m_valid/m_data    registered beat towards downstream
//   m_ready           downstream accepts
module pixel_reg_slice
   import sobel_pkg::*;
#(
   parameter int W = PIX_W + 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         s_valid,
   input  logic [W-1:0] s_data,
   output logic         s_ready,
   output logic         m_valid,
   output logic [W-1:0] m_data,
   input  logic         m_ready
);

   assign s_ready = !m_valid || m_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid <= 1'b0;
         m_data  <= '0;
      end else if (s_ready) begin
         m_valid <= s_valid;
         // Payload only moves with a real beat so a drained slot keeps its last value.
         if (s_valid) begin
            m_data <= s_data;
         end
      end
   end

endmodule

// File: rtl/pixel_stream_mux.sv
// rtl/pixel_stream_mux.sv - frame-aligned N-channel pixel stream selector
// Purpose: picks one of N_CH pixel streams, replaces pixels with FILL when disabled,
//   and registers the result; channel/enable changes take effect only between frames.
// Ports:
//   i_clk, i_rst       clock, async active-high reset
//   i_sel, i_enable    requested channel / pass-enable, applied at frame boundary
//   i_valid, i_data    per-channel input streams (channel k at [k*DATA_W +: DATA_W])
//   o_ready            per-channel ready
//   o_valid, o_data    registered output stream
//   i_ready            downstream ready
//   o_frame_start      marks the first output pixel of each frame
module pixel_stream_mux
   import sobel_pkg::*;
#(
   parameter int                DATA_W       = PIX_W,
   parameter int                N_CH         = 2,
   parameter int                FRAME_PIXELS = FRAME_PIXELS_DEF,
   parameter logic [DATA_W-1:0] FILL         = DATA_W'(PIX_BLACK),
   parameter bit                DRAIN_UNSEL  = 1'b1,
   localparam int               SEL_W        = $clog2(N_CH)
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [SEL_W-1:0]       i_sel,
   input  logic                   i_enable,
   input  logic [N_CH-1:0]        i_valid,
   input  logic [N_CH*DATA_W-1:0] i_data,
   output logic [N_CH-1:0]        o_ready,
   output logic                   o_valid,
   output logic [DATA_W-1:0]      o_data,
   input  logic                   i_ready,
   output logic                   o_frame_start
);

   localparam int               CNT_W    = cnt_width(FRAME_PIXELS);
   localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);

   logic [SEL_W-1:0]  act_sel;
   logic              act_en;
   logic [CNT_W-1:0]  pix_cnt;

   logic              load_ok;
   logic              take;
   logic              sel_valid;
   logic [DATA_W-1:0] sel_data;
   logic              frame_first;
   logic              frame_last;
   logic              cfg_load;
   logic              sel_in_range;
   logic [DATA_W:0]   slice_in;
   logic [DATA_W:0]   slice_out;

   always_comb begin
      sel_valid = 1'b0;
      sel_data  = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (act_sel == SEL_W'(k)) begin
            sel_valid = i_valid[k];
            sel_data  = i_data[k*DATA_W +: DATA_W];
         end
      end
   end

   assign take        = sel_valid && load_ok;
   assign frame_first = (pix_cnt == '0);
   assign frame_last  = (pix_cnt == LAST_PIX);
   // Shadow config reloads on the last pixel's take, or while idling before a frame's
   // first pixel; a take of pixel 0 must see the already-latched config, so no reload then.
   assign cfg_load     = (take && frame_last) || (frame_first && !take);
   assign sel_in_range = (int'(i_sel) < N_CH);

   // Unselected inputs either drain (discarded) or stall; all ready low while in reset.
   always_comb begin
      o_ready = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (i_rst) begin
            o_ready[k] = 1'b0;
         end else if (act_sel == SEL_W'(k)) begin
            o_ready[k] = load_ok;
         end else begin
            o_ready[k] = DRAIN_UNSEL;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         act_sel <= '0;
         act_en  <= 1'b0;
         pix_cnt <= '0;
      end else begin
         if (take) begin
            pix_cnt <= frame_last ? '0 : pix_cnt + 1'b1;
         end
         if (cfg_load) begin
            act_en <= i_enable;
            if (sel_in_range) begin
               act_sel <= i_sel;
            end
         end
      end
   end

   assign slice_in = {frame_first, (act_en ? sel_data : FILL)};

   pixel_reg_slice #(
      .W (DATA_W + 1)
   ) u_out_slice (
      .clk     (i_clk),
      .rst     (i_rst),
      .s_valid (take),
      .s_data  (slice_in),
      .s_ready (load_ok),
      .m_valid (o_valid),
      .m_data  (slice_out),
      .m_ready (i_ready)
   );

   assign o_frame_start = slice_out[DATA_W];
   assign o_data        = slice_out[DATA_W-1:0];

endmodule

// File: tb/tb_pixel_stream_mux.sv
// tb/tb_pixel_stream_mux.sv - self-checking bench for pixel_stream_mux
module tb_pixel_stream_mux;

   localparam int DW  = 24;
   localparam int NCH = 3;
   localparam int FP  = 4;
   localparam logic [DW-1:0] FILL_V = 24'h000000;

   typedef struct packed {
      logic          fs;
      logic [DW-1:0] d;
   } pix_t;

   logic              clk = 1'b0;
   logic              rst;
   logic [1:0]        sel;
   logic              en;
   logic [NCH-1:0]    vld;
   logic [NCH*DW-1:0] data;
   logic              rdy;
   logic [NCH-1:0]    o_ready, o_ready2;
   logic              o_valid, o_valid2, o_fs, o_fs2;
   logic [DW-1:0]     o_data, o_data2;

   always #5 clk = ~clk;

   pixel_stream_mux #(.DATA_W(DW), .N_CH(NCH), .FRAME_PIXELS(FP), .FILL(FILL_V), .DRAIN_UNSEL(1'b1)) dut (
      .i_clk(clk), .i_rst(rst), .i_sel(sel), .i_enable(en), .i_valid(vld), .i_data(data),
      .o_ready(o_ready), .o_valid(o_valid), .o_data(o_data), .i_ready(rdy), .o_frame_start(o_fs));

   pixel_stream_mux #(.DATA_W(DW), .N_CH(NCH), .FRAME_PIXELS(FP), .FILL(FILL_V), .DRAIN_UNSEL(1'b0)) dut_stall (
      .i_clk(clk), .i_rst(rst), .i_sel(sel), .i_enable(en), .i_valid(vld), .i_data(data),
      .o_ready(o_ready2), .o_valid(o_valid2), .o_data(o_data2), .i_ready(rdy), .o_frame_start(o_fs2));

   int checks = 0;
   int errors = 0;

   // Reference model: pending output pixels, frame position and the latched frame config.
   pix_t q[$];
   int   m_cnt, m_sel, n_in, n_out, frames_done;
   bit   m_en;

   bit             c_fire, c_exp_ok;
   pix_t           c_obs, c_exp;
   logic           c_obs_v, c_exp_v;
   logic [NCH-1:0] c_obs_rdy, c_exp_rdy;
   logic [NCH-1:0] unsel2_seen;

   task automatic model_reset();
      q.delete();
      m_cnt = 0;
      m_sel = 0;
      m_en  = 1'b0;
   endtask

   task automatic set_ch(input int k, input logic [DW-1:0] v);
      data[k*DW +: DW] = v;
   endtask

   // One clock: sample just after the falling edge, advance the model, move to next falling edge.
   task automatic run_cycle();
      bit acc;
      #1;
      c_obs_v   = o_valid;
      c_exp_v   = (q.size() != 0);
      c_obs_rdy = o_ready;
      for (int k = 0; k < NCH; k++) begin
         c_exp_rdy[k] = (k == m_sel) ? ((q.size() == 0) || rdy) : 1'b1;
         if (k != m_sel) unsel2_seen[k] = unsel2_seen[k] | o_ready2[k];
      end
      c_fire   = o_valid && rdy;
      c_obs    = {o_fs, o_data};
      c_exp_ok = 1'b0;
      c_exp    = '0;
      if (c_fire) begin
         n_out++;
         if (q.size() > 0) begin
            c_exp    = q.pop_front();
            c_exp_ok = 1'b1;
         end
      end
      acc = vld[m_sel] && c_exp_rdy[m_sel];
      if (acc) begin
         q.push_back({(m_cnt == 0), (m_en ? data[m_sel*DW +: DW] : FILL_V)});
         n_in++;
      end
      if ((acc && m_cnt == FP - 1) || (m_cnt == 0 && !acc)) begin
         if (sel < NCH) m_sel = int'(sel);
         m_en = en;
      end
      if (acc) begin
         if (m_cnt == FP - 1) begin
            m_cnt = 0;
            frames_done++;
         end else begin
            m_cnt++;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; sel = 2'd0; en = 1'b0; vld = '0; data = '0; rdy = 1'b1;
      unsel2_seen = '0; n_in = 0; n_out = 0; frames_done = 0;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      #1;
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
      checks++; if (o_data !== 24'h0) begin errors++; $display("FAIL reset_data: got %h expected 000000", o_data); end
      checks++; if (o_fs !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %b expected 0", o_fs); end
      checks++; if (o_ready !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b expected 000", o_ready); end
      checks++; if (o_ready2 !== 3'b000) begin errors++; $display("FAIL reset_ready_stall: got %b expected 000", o_ready2); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_pass_through();
      int nout = 0;
      int nfs  = 0;
      en = 1'b1; sel = 2'd0; rdy = 1'b1; vld = '0;
      set_ch(0, 24'h112233);
      for (int c = 0; c < 6; c++) begin
         vld = (c >= 1 && c <= 4) ? 3'b001 : 3'b000;
         run_cycle();
         checks++; if (c_obs_v !== c_exp_v) begin errors++; $display("FAIL pass_valid: got %b expected %b", c_obs_v, c_exp_v); end
         checks++; if (c_obs_rdy !== c_exp_rdy) begin errors++; $display("FAIL pass_ready: got %b expected %b", c_obs_rdy, c_exp_rdy); end
         if (c_fire) begin
            nout++;
            if (c_obs.fs) nfs++;
            checks++; if (!c_exp_ok || c_obs !== c_exp) begin errors++; $display("FAIL pass_pixel: got %h expected %h", c_obs, c_exp); end
            checks++; if (c_obs.d !== 24'h112233) begin errors++; $display("FAIL pass_data: got %h expected 112233", c_obs.d); end
         end
      end
      checks++; if (nout !== 4) begin errors++; $display("FAIL pass_count: got %0d expected 4", nout); end
      checks++; if (nfs !== 1) begin errors++; $display("FAIL pass_fs_count: got %0d expected 1", nfs); end
   endtask

   task automatic test_mid_frame_switch();
      pix_t          outs[$];
      logic [DW-1:0] exp_d [5];
      logic          exp_fs [5];
      exp_d  = '{24'hA00000, 24'hA00001, 24'hA00002, 24'hA00003, 24'h000000};
      exp_fs = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      en = 1'b1; sel = 2'd0; rdy = 1'b1;
      set_ch(1, 24'hABCDEF);
      for (int c = 0; c < 7; c++) begin
         if (c == 2) begin sel = 2'd1; en = 1'b0; end
         vld = (c < 5) ? 3'b011 : 3'b000;
         set_ch(0, 24'hA00000 + 24'(c));
         run_cycle();
         checks++; if (c_obs_v !== c_exp_v) begin errors++; $display("FAIL switch_valid: got %b expected %b", c_obs_v, c_exp_v); end
         checks++; if (c_obs_rdy !== c_exp_rdy) begin errors++; $display("FAIL switch_ready: got %b expected %b", c_obs_rdy, c_exp_rdy); end
         if (c_fire) begin
            outs.push_back(c_obs);
            checks++; if (!c_exp_ok || c_obs !== c_exp) begin errors++; $display("FAIL switch_pixel: got %h expected %h", c_obs, c_exp); end
         end
      end
      checks++; if (outs.size() != 5) begin errors++; $display("FAIL switch_count: got %0d expected 5", outs.size()); end
      for (int i = 0; i < 5 && i < outs.size(); i++) begin
         checks++; if (outs[i].d !== exp_d[i] || outs[i].fs !== exp_fs[i]) begin
            errors++; $display("FAIL switch_px%0d: got %h/%b expected %h/%b", i, outs[i].d, outs[i].fs, exp_d[i], exp_fs[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      int guard = 0;
      sel = 2'd0; en = 1'b1; rdy = 1'b1; vld = 3'b011;
      while (!(m_cnt == 0 && m_sel == 0 && m_en) && guard < 20) begin
         run_cycle();
         guard++;
      end
      checks++; if (guard >= 20) begin errors++; $display("FAIL bp_boundary: got timeout expected frame boundary"); end
      vld = 3'b001;
      set_ch(0, 24'h5A5A5A);
      for (int c = 0; c < 6; c++) begin
         rdy = !(c >= 1 && c <= 3);
         if (c >= 4) vld = 3'b000;
         if (c >= 1) set_ch(0, 24'h5A5A5A + 24'(c));
         run_cycle();
         checks++; if (c_obs_v !== c_exp_v) begin errors++; $display("FAIL bp_valid: got %b expected %b", c_obs_v, c_exp_v); end
         checks++; if (c_obs_rdy !== c_exp_rdy) begin errors++; $display("FAIL bp_ready: got %b expected %b", c_obs_rdy, c_exp_rdy); end
         if (c_fire) begin
            checks++; if (!c_exp_ok || c_obs !== c_exp) begin errors++; $display("FAIL bp_pixel: got %h expected %h", c_obs, c_exp); end
         end
         if (c >= 1 && c <= 3) begin
            checks++; if (c_obs.d !== 24'h5A5A5A) begin errors++; $display("FAIL bp_hold: got %h expected 5a5a5a", c_obs.d); end
            checks++; if (c_obs_rdy[0] !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b expected 0", c_obs_rdy[0]); end
         end
      end
      checks++; if (n_in != n_out || q.size() != 0) begin
         errors++; $display("FAIL bp_conservation: got %0d out expected %0d", n_out, n_in);
      end
   endtask

   task automatic test_random();
      int start = frames_done;
      int cyc = 0;
      while (frames_done - start < 10 && cyc < 1000) begin
         vld = 3'($urandom_range(0, 7));
         rdy = ($urandom_range(0, 3) != 0);
         sel = 2'($urandom_range(0, 3));
         en  = 1'($urandom_range(0, 1));
         for (int k = 0; k < NCH; k++) set_ch(k, 24'($urandom));
         run_cycle();
         cyc++;
         checks++; if (c_obs_v !== c_exp_v) begin errors++; $display("FAIL rand_valid: got %b expected %b", c_obs_v, c_exp_v); end
         checks++; if (c_obs_rdy !== c_exp_rdy) begin errors++; $display("FAIL rand_ready: got %b expected %b", c_obs_rdy, c_exp_rdy); end
         if (c_fire) begin
            checks++; if (!c_exp_ok || c_obs !== c_exp) begin errors++; $display("FAIL rand_pixel: got %h expected %h", c_obs, c_exp); end
         end
      end
      checks++; if (frames_done - start < 10) begin errors++; $display("FAIL rand_frames: got %0d expected 10", frames_done - start); end
   endtask

   task automatic test_bad_sel_and_reset();
      int guard = 0;
      sel = 2'd2; en = 1'b1; rdy = 1'b1; vld = 3'b111;
      set_ch(0, 24'h0A0A0A); set_ch(1, 24'h0B0B0B); set_ch(2, 24'hC2C2C2);
      while (m_cnt != 0 && guard < 20) begin run_cycle(); guard++; end
      vld = 3'b000;
      run_cycle();
      run_cycle();
      sel = 2'd3;
      run_cycle();
      run_cycle();
      vld = 3'b111;
      for (int c = 0; c < 2; c++) begin
         run_cycle();
         checks++; if (c_obs_rdy !== c_exp_rdy) begin errors++; $display("FAIL badsel_ready: got %b expected %b", c_obs_rdy, c_exp_rdy); end
         if (c_fire) begin
            checks++; if (!c_exp_ok || c_obs !== c_exp) begin errors++; $display("FAIL badsel_pixel: got %h expected %h", c_obs, c_exp); end
            checks++; if (c_obs.d !== 24'hC2C2C2) begin errors++; $display("FAIL badsel_data: got %h expected c2c2c2", c_obs.d); end
         end
      end
      checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL badsel_inflight: got %b expected 1", o_valid); end
      rst = 1'b1;
      #1;
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b expected 0", o_valid); end
      checks++; if (o_ready !== 3'b000) begin errors++; $display("FAIL midreset_ready: got %b expected 000", o_ready); end
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 2; c++) begin
         run_cycle();
         if (c == 1) begin
            checks++; if (c_obs_v !== 1'b1 || c_obs.fs !== 1'b1) begin
               errors++; $display("FAIL midreset_fs: got %b/%b expected 1/1", c_obs_v, c_obs.fs);
            end
         end
         if (c_fire) begin
            checks++; if (!c_exp_ok || c_obs !== c_exp) begin errors++; $display("FAIL midreset_pixel: got %h expected %h", c_obs, c_exp); end
         end
      end
      vld = 3'b000;
      run_cycle();
   endtask

   task automatic test_stall_unselected();
      checks++; if (unsel2_seen !== 3'b000) begin
         errors++; $display("FAIL stall_unselected_ready: got %b expected 000", unsel2_seen);
      end
   endtask

   initial begin
      test_reset();
      test_pass_through();
      test_mid_frame_switch();
      test_backpressure();
      test_random();
      test_bad_sel_and_reset();
      test_stall_unselected();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
